ram_port_initiator: RTL and testbench

Initiator for one port of the block-RAM word memory (`ram_dualport`-style port). It converts a valid/ready load/store request stream (byte/half/word, signed/unsigned) into RAM port strobes, enforces the port's one-cycle write-merge hazard, and extracts and extends load data. It returns exactly one in-order response per accepted request through a 3-entry buffer. It sits between the core's memory stage (or a bus bridge) and the RAM.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/ram_port_resp_fifo.sv | 51 +++++
 rtl/ram_port_initiator.sv | 115 +++++++++++
 tb/tb_ram_port_initiator.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for word-memory port initiators: access sizes, byte strobes
// and the packed response format {err, data}.
package mem_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  localparam int RESP_W = 33;

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic [1:0] size;
    logic       is_signed;
    logic [1:0] lane;
    logic       err;
  } p1_t;

endpackage

// File: rtl/ram_port_resp_fifo.sv
// Three-entry response buffer; push and pop may happen in the same cycle at any
// occupancy, and the head reads as zero whenever the buffer is empty.
module ram_port_resp_fifo
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [RESP_W-1:0] push_data,
  input  logic              pop,
  output logic [RESP_W-1:0] head,
  output logic [1:0]        count
);

  logic [RESP_W-1:0] mem [3];
  logic [1:0]        rd_ptr;
  logic [1:0]        wr_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd3) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ram_port_initiator.sv
// Load/store initiator for one block-RAM port: issues strobes in the accept
// cycle, extracts load data one cycle later and returns in-order responses.
module ram_port_initiator
  import mem_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_WE,
  input  logic [1:0]       REQ_SIZE,
  input  logic             REQ_SIGNED,
  input  logic [WIDTH+1:0] REQ_ADDR,
  input  logic [31:0]      REQ_WDATA,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic [31:0]      RESP_DATA,
  output logic             RESP_ERR,
  output logic             M_RDEN,
  output logic [WIDTH+1:0] M_RADDR,
  input  logic [31:0]      M_RDATA,
  output logic             M_WREN,
  output logic [3:0]       M_WSTRB,
  output logic [WIDTH+1:0] M_WADDR,
  output logic [31:0]      M_WDATA
);

  p1_t               p1;
  logic              wr_last;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic              accept;
  logic              req_err;
  logic [RESP_W-1:0] push_data;
  logic [RESP_W-1:0] head;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      MEM_SIZE_B: return 1'b0;
      MEM_SIZE_H: return lane[0];
      MEM_SIZE_W: return lane != 2'b00;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] strobe(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: return STRB_B;
      MEM_SIZE_H: return STRB_H;
      default:    return STRB_W;
    endcase
  endfunction

  // Only aligned lanes reach here, so a half always sits at lane 0 or 2.
  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] size,
                                          input logic sgn, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = rdata[{lane[1], 4'b0000} +: 16];
    case (size)
      MEM_SIZE_B: return {{24{sgn & b[7]}}, b};
      MEM_SIZE_H: return {{16{sgn & h[15]}}, h};
      default:    return rdata;
    endcase
  endfunction

  assign occupancy = {1'b0, fifo_count} + {2'b00, p1.valid};
  assign REQ_READY = !RST && (occupancy <= 3'd2) && !wr_last;
  assign accept    = REQ_VALID && REQ_READY;
  assign req_err   = misaligned(REQ_SIZE, REQ_ADDR[1:0]);

  assign M_RADDR = REQ_ADDR;
  assign M_WADDR = REQ_ADDR;
  assign M_RDEN  = accept && !REQ_WE && !req_err;
  assign M_WREN  = accept && REQ_WE && !req_err;
  assign M_WSTRB = M_WREN ? strobe(REQ_SIZE) : 4'b0000;
  assign M_WDATA = M_WREN ? REQ_WDATA : 32'd0;

  // The RAM answers with write-merge data the cycle after a write, so that
  // cycle is kept free of new accepts via wr_last.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p1      <= '0;
      wr_last <= 1'b0;
    end else begin
      p1.valid     <= accept;
      p1.is_load   <= !REQ_WE;
      p1.size      <= REQ_SIZE;
      p1.is_signed <= REQ_SIGNED;
      p1.lane      <= REQ_ADDR[1:0];
      p1.err       <= req_err;
      wr_last      <= M_WREN;
    end
  end

  assign push_data = {p1.err, (p1.is_load && !p1.err) ?
                      extract(M_RDATA, p1.size, p1.is_signed, p1.lane) : 32'd0};

  ram_port_resp_fifo u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (p1.valid),
    .push_data (push_data),
    .pop       (RESP_VALID && RESP_READY),
    .head      (head),
    .count     (fifo_count)
  );

  assign RESP_VALID          = fifo_count != 2'd0;
  assign {RESP_ERR, RESP_DATA} = head;

endmodule

// File: tb/tb_ram_port_initiator.sv
// Directed bench for ram_port_initiator with a small byte-lane RAM model that
// returns read data the cycle after M_RDEN.
module tb_ram_port_initiator;

  logic        CLK;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGNED;
  logic [11:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        RESP_VALID;
  logic        RESP_READY;
  logic [31:0] RESP_DATA;
  logic        RESP_ERR;
  logic        M_RDEN;
  logic [11:0] M_RADDR;
  logic [31:0] M_RDATA;
  logic        M_WREN;
  logic [3:0]  M_WSTRB;
  logic [11:0] M_WADDR;
  logic [31:0] M_WDATA;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rden_cnt = 0;

  logic [32:0] resp_q[$];
  int          resp_cyc[$];
  logic [31:0] ram [1024];

  ram_port_initiator #(.WIDTH(10)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_WE     (REQ_WE),
    .REQ_SIZE   (REQ_SIZE),
    .REQ_SIGNED (REQ_SIGNED),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_WDATA  (REQ_WDATA),
    .RESP_VALID (RESP_VALID),
    .RESP_READY (RESP_READY),
    .RESP_DATA  (RESP_DATA),
    .RESP_ERR   (RESP_ERR),
    .M_RDEN     (M_RDEN),
    .M_RADDR    (M_RADDR),
    .M_RDATA    (M_RDATA),
    .M_WREN     (M_WREN),
    .M_WSTRB    (M_WSTRB),
    .M_WADDR    (M_WADDR),
    .M_WDATA    (M_WDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // RAM port model: strobes and data arrive unshifted and are placed at the lane.
  always @(posedge CLK) begin
    if (M_WREN) begin
      for (int b = 0; b < 4; b++) begin
        if (M_WSTRB[b] && (b + int'(M_WADDR[1:0]) < 4))
          ram[M_WADDR[11:2]][8*(b + int'(M_WADDR[1:0])) +: 8] <= M_WDATA[8*b +: 8];
      end
    end
    if (M_RDEN) M_RDATA <= ram[M_RADDR[11:2]];
    else if (M_WREN) M_RDATA <= 32'hBAD0_0BAD;
  end

  always @(negedge CLK) begin
    if (!RST && RESP_VALID && RESP_READY) begin
      resp_q.push_back({RESP_ERR, RESP_DATA});
      resp_cyc.push_back(cyc);
    end
    if (M_RDEN) rden_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [32:0] q_at(input int i);
    if (i < resp_q.size()) return resp_q[i];
    return 'x;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [11:0] addr, input logic [31:0] wd);
    REQ_VALID  = v;
    REQ_WE     = we;
    REQ_SIZE   = size;
    REQ_SIGNED = sgn;
    REQ_ADDR   = addr;
    REQ_WDATA  = wd;
  endtask

  // Presents one request until accepted; returns one cycle after the accept.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [11:0] addr, input logic [31:0] wd);
    bit got;
    got = 0;
    drive(1'b1, we, size, sgn, addr, wd);
    for (int n = 0; n < 50; n++) begin
      @(negedge CLK);
      if (REQ_READY) begin
        got = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL issue_timeout: got no accept, required accept for addr %h", addr);
    end
    tick();
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    for (int k = 0; k < 40 && resp_q.size() < n; k++) tick();
    checks++;
    if (resp_q.size() < n) begin
      errors++;
      $display("[TB] FAIL resp_timeout: got %0d responses, required %0d", resp_q.size(), n);
    end
  endtask

  task automatic clear_q();
    resp_q.delete();
    resp_cyc.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    RESP_READY = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 12'h010, 32'hFFFF_FFFF);
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_ready: got %b required 0", REQ_READY); end
    checks++; if (RESP_VALID !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_valid: got %b required 0", RESP_VALID); end
    checks++; if (RESP_DATA !== 32'd0) begin errors++; $display("[TB] FAIL rst_resp_data: got %h required 0", RESP_DATA); end
    checks++; if (RESP_ERR !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_err: got %b required 0", RESP_ERR); end
    checks++; if (M_RDEN !== 1'b0) begin errors++; $display("[TB] FAIL rst_rden: got %b required 0", M_RDEN); end
    checks++; if (M_WREN !== 1'b0) begin errors++; $display("[TB] FAIL rst_wren: got %b required 0", M_WREN); end
    checks++; if (M_WSTRB !== 4'd0) begin errors++; $display("[TB] FAIL rst_wstrb: got %b required 0000", M_WSTRB); end
    checks++; if (M_WDATA !== 32'd0) begin errors++; $display("[TB] FAIL rst_wdata: got %h required 0", M_WDATA); end
    tick();
    REQ_VALID = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_ready: got %b required 1", REQ_READY); end
    tick();
  endtask

  task automatic test_store_load();
    clear_q();
    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 2'b00, 1'b1, 12'h013, 32'd0);
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("[TB] FAIL wr_last_bubble: got %b required 0", REQ_READY); end
    tick();
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("[TB] FAIL wr_last_release: got %b required 1", REQ_READY); end
    tick();
    REQ_VALID = 1'b0;
    wait_resp(2);
    checks++; if (q_at(0) !== 33'h0) begin errors++; $display("[TB] FAIL store_resp: got %h required 0", q_at(0)); end
    checks++; if (q_at(1) !== {1'b0, 32'hFFFF_FFDE}) begin errors++; $display("[TB] FAIL sbyte_load: got %h required 0ffffffde", q_at(1)); end
  endtask

  task automatic test_half();
    logic [32:0] exp [5];
    exp[0] = 33'h0;
    exp[1] = 33'h0;
    exp[2] = {1'b0, 32'h0000_8001};
    exp[3] = {1'b0, 32'hFFFF_8001};
    exp[4] = {1'b0, 32'h8001_5678};
    clear_q();
    issue(1'b1, 2'b10, 1'b0, 12'h020, 32'h1234_5678);
    tick();
    drive(1'b1, 1'b1, 2'b01, 1'b0, 12'h022, 32'hABCD_8001);
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1 || M_WREN !== 1'b1) begin errors++; $display("[TB] FAIL half_store_wren: got ready %b wren %b required 1 1", REQ_READY, M_WREN); end
    checks++; if (M_WSTRB !== 4'b0011) begin errors++; $display("[TB] FAIL half_store_strb: got %b required 0011", M_WSTRB); end
    checks++; if (M_WDATA !== 32'hABCD_8001) begin errors++; $display("[TB] FAIL half_store_wdata: got %h required abcd8001", M_WDATA); end
    tick();
    REQ_VALID = 1'b0;
    issue(1'b0, 2'b01, 1'b0, 12'h022, 32'd0);
    issue(1'b0, 2'b01, 1'b1, 12'h022, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 12'h020, 32'd0);
    wait_resp(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (q_at(i) !== exp[i]) begin
        errors++;
        $display("[TB] FAIL half_resp_%0d: got %h required %h", i, q_at(i), exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    int r0;
    clear_q();
    r0 = rden_cnt;
    issue(1'b0, 2'b10, 1'b0, 12'h001, 32'd0);
    issue(1'b0, 2'b01, 1'b0, 12'h003, 32'd0);
    issue(1'b0, 2'b11, 1'b0, 12'h000, 32'd0);
    checks++; if (rden_cnt - r0 != 0) begin errors++; $display("[TB] FAIL err_no_rden: got %0d reads required 0", rden_cnt - r0); end
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'd0);
    wait_resp(4);
    checks++; if (rden_cnt - r0 != 1) begin errors++; $display("[TB] FAIL err_one_rden: got %0d reads required 1", rden_cnt - r0); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (q_at(i) !== {1'b1, 32'd0}) begin
        errors++;
        $display("[TB] FAIL err_resp_%0d: got %h required 100000000", i, q_at(i));
      end
    end
    checks++; if (q_at(3) !== {1'b0, 32'hDEAD_BEEF}) begin errors++; $display("[TB] FAIL err_followup: got %h required 0deadbeef", q_at(3)); end
  endtask

  task automatic test_backpressure();
    logic [11:0] addrs [4];
    logic [32:0] exp [4];
    int acc;
    addrs[0] = 12'h100; addrs[1] = 12'h104; addrs[2] = 12'h108; addrs[3] = 12'h10C;
    ram[64] = 32'h0000_1111;
    ram[65] = 32'h2222_0000;
    ram[66] = 32'h80F0_7F81;
    ram[67] = 32'h4444_4444;
    exp[0] = {1'b0, 32'h0000_1111};
    exp[1] = {1'b0, 32'h2222_0000};
    exp[2] = {1'b0, 32'h80F0_7F81};
    exp[3] = {1'b0, 32'h4444_4444};
    clear_q();
    RESP_READY = 1'b0;
    acc = 0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, addrs[0], 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (REQ_READY) acc++;
      tick();
      if (acc < 4) REQ_ADDR = addrs[acc];
    end
    @(negedge CLK);
    checks++; if (acc != 3) begin errors++; $display("[TB] FAIL bp_accepts: got %0d required 3", acc); end
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %b required 0", REQ_READY); end
    checks++; if (RESP_VALID !== 1'b1) begin errors++; $display("[TB] FAIL bp_resp_valid: got %b required 1", RESP_VALID); end
    tick();
    RESP_READY = 1'b1;
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_at_pop: got %b required 0", REQ_READY); end
    tick();
    @(negedge CLK);
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_resume: got %b required 1", REQ_READY); end
    tick();
    REQ_VALID = 1'b0;
    wait_resp(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_at(i) !== exp[i]) begin
        errors++;
        $display("[TB] FAIL bp_resp_%0d: got %h required %h", i, q_at(i), exp[i]);
      end
    end
  endtask

  localparam logic [46:0] STREAM [8] = '{
    {12'h108, 2'b00, 1'b1, 32'hFFFF_FF81},
    {12'h108, 2'b00, 1'b0, 32'h0000_0081},
    {12'h109, 2'b00, 1'b1, 32'h0000_007F},
    {12'h10A, 2'b00, 1'b1, 32'hFFFF_FFF0},
    {12'h10B, 2'b00, 1'b0, 32'h0000_0080},
    {12'h108, 2'b01, 1'b1, 32'h0000_7F81},
    {12'h10A, 2'b01, 1'b1, 32'hFFFF_80F0},
    {12'h104, 2'b10, 1'b0, 32'h2222_0000}
  };

  task automatic test_streaming();
    logic [46:0] v;
    int first_acc;
    clear_q();
    RESP_READY = 1'b1;
    first_acc = -1;
    for (int i = 0; i < 8; i++) begin
      v = STREAM[i];
      drive(1'b1, 1'b0, v[34:33], v[32], v[46:35], 32'd0);
      @(negedge CLK);
      checks++;
      if (REQ_READY !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_ready_%0d: got %b required 1", i, REQ_READY);
      end
      if (i == 0) first_acc = cyc;
      tick();
    end
    REQ_VALID = 1'b0;
    wait_resp(8);
    for (int i = 0; i < 8; i++) begin
      v = STREAM[i];
      checks++;
      if (q_at(i) !== {1'b0, v[31:0]}) begin
        errors++;
        $display("[TB] FAIL stream_resp_%0d: got %h required %h", i, q_at(i), {1'b0, v[31:0]});
      end
    end
    checks++;
    if (resp_cyc.size() == 0 || resp_cyc[0] != first_acc + 2) begin
      errors++;
      $display("[TB] FAIL stream_latency: got first response at cycle %0d required %0d",
               (resp_cyc.size() == 0) ? -1 : resp_cyc[0], first_acc + 2);
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    RESP_READY = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 12'h100, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (REQ_READY !== 1'b1) begin
        errors++;
        $display("[TB] FAIL mid_fill_%0d: got %b required 1", i, REQ_READY);
      end
      tick();
    end
    REQ_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (RESP_VALID !== 1'b1) begin errors++; $display("[TB] FAIL mid_buffered: got %b required 1", RESP_VALID); end
    tick();
    RST = 1'b0;
    RESP_READY = 1'b1;
    @(negedge CLK);
    checks++; if (RESP_VALID !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b required 0", RESP_VALID); end
    checks++; if (REQ_READY !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b required 1", REQ_READY); end
    checks++; if (RESP_DATA !== 32'd0) begin errors++; $display("[TB] FAIL mid_rst_data: got %h required 0", RESP_DATA); end
    repeat (6) tick();
    checks++; if (resp_q.size() != 0) begin errors++; $display("[TB] FAIL mid_no_stale: got %0d responses required 0", resp_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    M_RDATA = 32'd0;
    test_reset();
    test_store_load();
    test_half();
    test_errors();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
